data_memory_bus_responder: RTL and testbench
============================================

Name: data_memory_bus_responder

Overview:
- Responder end of the core's data-memory bus.
- Accepts read/write requests driven by the core's dmem path: address, write data, byte enables, and read/write enables.
- Services them from an internal word-addressed RAM, with a configurable wait-state count and a one-cycle ready pulse.
- Lets the multicycle/pipelined core variants be simulated against a memory with real latency, replacing the zero-latency testbench array.

Parameters:
- ADDR_BASE, 32'h8000_0000, byte address of RAM word 0; must be 4-byte aligned.
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, at least 2.
- WAIT_STATES, 1, idle cycles between request acceptance and response (0–15).

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- bus_address  in  32  byte address of request.
- bus_write_data  in  32  write data, lane-aligned.
- bus_byte_enable  in  4  write lane mask; bit i enables bits [8i+7:8i].
- bus_read_enable  in  1  read request.
- bus_write_enable  in  1  write request.
- bus_read_data  out  32  read response data.
- bus_ready  out  1  one-cycle pulse; response/commit complete.
- bus_error  out  1  qualifies bus_ready; request rejected.

Behaviour:
- Reset (reset low, asynchronous):
  - State IDLE; bus_ready=0, bus_error=0, bus_read_data=0, wait counter=0.
  - RAM contents are not reset; benches preload them.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If bus_read_enable|bus_write_enable=1 at the edge, latch address, write data, byte enables, kind (read/write) and the decode result.
  - Go to WAIT with counter=WAIT_STATES-1. If WAIT_STATES=0, go directly to RESP.
- WAIT: counter decrements each cycle; at 0, go to RESP on the next edge.
- Entering RESP (that edge):
  - Valid write: commit enabled byte lanes to RAM.
  - Valid read: register the full word into bus_read_data.
  - bus_ready=1, bus_error set per decode.
- RESP lasts exactly one cycle, then returns to IDLE. Bus inputs sampled during WAIT/RESP are ignored.
- Latency: enables sampled at edge N → bus_ready high during cycle N+WAIT_STATES+1.
- Initiator contract: hold request stable until bus_ready, and deassert the enables in the cycle after bus_ready unless issuing a new request. Enables still high in IDLE are accepted as a new request.
- Decode:
  - In range iff ADDR_BASE ≤ address < ADDR_BASE+4*DEPTH_WORDS, using unsigned 33-bit compare, so no wrap-around at 2^32.
  - Word index = (address−ADDR_BASE)>>2; address[1:0] is ignored.
- Error cases, all with bus_error=1 alongside bus_ready, no RAM write, bus_read_data=0:
  - Out-of-range address.
  - bus_read_enable and bus_write_enable both high.
- Write with byte_enable=4'b0000: valid no-op; ready=1, error=0.
- Reads ignore byte_enable and return the full word; sub-word extraction belongs to the core.
- bus_read_data holds the last read response until the next read response. Writes and errored writes do not change it; errored reads set it to 0.
- bus_ready and bus_error are 0 outside RESP.
- Reset asserted mid-transaction aborts it: a pending write not yet committed is lost, and no ready pulse occurs.
- Read-after-write to the same word in consecutive transactions returns the new data.

Test Plan:
- Reset then idle: reset low 3 cycles, release → ready=0, error=0, read_data=0 for 10 cycles, no requests.
- Write then read, WAIT_STATES=1:
  - Write 0x8000_0010, data 0xCAFEBABE, be=4'hF at edge 0 → ready pulse in cycle 2, error=0.
  - Read same address → ready in cycle 2 of the read, read_data=0xCAFEBABE.
- Byte lanes:
  - Preload word 4 = 0x11223344.
  - Write 0x8000_0010, data 0xAABBCCDD, be=4'b0101 → readback 0x11BB33DD.
  - Then be=4'b0000 → word unchanged, error=0.
- Errors:
  - Read 0x7FFF_FFFC → ready+error, read_data=0.
  - Write 0x8000_1000 (DEPTH 1024) → error, RAM unchanged.
  - Read+write both high → error.
- Latency sweep: WAIT_STATES=0 → ready 1 cycle after acceptance; WAIT_STATES=3 → ready 4 cycles after acceptance.
- Reset mid-write: WAIT_STATES=3, assert reset during WAIT → no ready pulse, state IDLE, later readback of that word shows old value.

Source files
------------

// File: rtl/data_memory_bus_responder.sv
// Responder end of the core's data-memory bus: word-addressed RAM behind a
// request/ready handshake with a configurable number of wait states.
module data_memory_bus_responder #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] bus_address,
    input  logic [31:0] bus_write_data,
    input  logic [3:0]  bus_byte_enable,
    input  logic        bus_read_enable,
    input  logic        bus_write_enable,
    output logic [31:0] bus_read_data,
    output logic        bus_ready,
    output logic        bus_error
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = 4;
    localparam logic [32:0] BASE_33  = {1'b0, ADDR_BASE};
    localparam logic [32:0] LIMIT_33 = BASE_33 + 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [CNT_W-1:0] CNT_INIT =
        (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;

    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_be;
    logic              r_is_rd;
    logic              r_is_wr;
    logic              r_err;

    logic              r_ready;
    logic              r_error;
    logic [31:0]       r_read_data;

    logic [31:0]       r_mem [DEPTH_WORDS];

    logic              w_req;
    logic              w_accept;
    logic [31:0]       w_cur_addr;
    logic [31:0]       w_cur_wdata;
    logic [3:0]        w_cur_be;
    logic              w_cur_rd;
    logic              w_cur_wr;
    logic              w_cur_err;
    logic              w_dec_err;
    logic [32:0]       w_addr_33;
    logic [31:0]       w_off;
    logic [IDX_W-1:0]  w_idx;
    logic [31-IDX_W:0] w_unused_off;

    logic              w_ready_nxt;
    logic              w_error_nxt;
    logic              w_mem_we;
    logic [31:0]       w_rdata_nxt;

    assign w_req    = bus_read_enable | bus_write_enable;
    assign w_accept = (r_state == S_IDLE) && w_req;

    // In IDLE the live bus is the request (needed when there are no wait states).
    assign w_cur_addr  = (r_state == S_IDLE) ? bus_address      : r_addr;
    assign w_cur_wdata = (r_state == S_IDLE) ? bus_write_data   : r_wdata;
    assign w_cur_be    = (r_state == S_IDLE) ? bus_byte_enable  : r_be;
    assign w_cur_rd    = (r_state == S_IDLE) ? bus_read_enable  : r_is_rd;
    assign w_cur_wr    = (r_state == S_IDLE) ? bus_write_enable : r_is_wr;
    assign w_cur_err   = (r_state == S_IDLE) ? w_dec_err        : r_err;

    // 33-bit compare keeps the window from wrapping past 2^32.
    assign w_addr_33    = {1'b0, w_cur_addr};
    assign w_dec_err    = (w_addr_33 < BASE_33) || (w_addr_33 >= LIMIT_33) ||
                          (bus_read_enable && bus_write_enable);
    assign w_off        = w_cur_addr - ADDR_BASE;
    assign w_idx        = w_off[IDX_W+1:2];
    assign w_unused_off = {w_off[31:IDX_W+2], w_off[1:0]};

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_state_nxt = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Response values loaded on the edge that enters RESP
    always_comb begin
        w_ready_nxt = (w_state_nxt == S_RESP);
        w_error_nxt = w_ready_nxt && w_cur_err;
        w_mem_we    = w_ready_nxt && w_cur_wr && !w_cur_err;
        w_rdata_nxt = r_read_data;
        if (w_ready_nxt && w_cur_rd) begin
            w_rdata_nxt = w_cur_err ? 32'h0 : r_mem[w_idx];
        end
    end

    // Request latch, wait counter and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_is_rd     <= 1'b0;
            r_is_wr     <= 1'b0;
            r_err       <= 1'b0;
            r_ready     <= 1'b0;
            r_error     <= 1'b0;
            r_read_data <= '0;
        end else begin
            if (w_accept) begin
                r_cnt   <= CNT_INIT;
                r_addr  <= bus_address;
                r_wdata <= bus_write_data;
                r_be    <= bus_byte_enable;
                r_is_rd <= bus_read_enable;
                r_is_wr <= bus_write_enable;
                r_err   <= w_dec_err;
            end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            r_ready     <= w_ready_nxt;
            r_error     <= w_error_nxt;
            r_read_data <= w_rdata_nxt;
        end
    end

    // RAM contents survive reset; only enabled byte lanes are written.
    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_cur_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_cur_wdata[8*b +: 8];
                end
            end
        end
    end

    assign bus_read_data = r_read_data;
    assign bus_ready     = r_ready;
    assign bus_error     = r_error;

endmodule

// File: tb/tb_data_memory_bus_responder.sv
// Directed bench for data_memory_bus_responder: three instances with 1, 0 and 3
// wait states, a vector table of transactions and hand-written reset sequences.
module tb_data_memory_bus_responder;

    logic        clk;
    logic        rst_n    [3];
    logic [31:0] b_addr   [3];
    logic [31:0] b_wdata  [3];
    logic [3:0]  b_be     [3];
    logic        b_rd     [3];
    logic        b_wr     [3];
    logic [31:0] b_rdata  [3];
    logic        b_ready  [3];
    logic        b_error  [3];

    int n_cmp  = 0;
    int n_fail = 0;

    data_memory_bus_responder #(.WAIT_STATES(1)) u_dut_ws1 (
        .clock(clk), .reset(rst_n[0]), .bus_address(b_addr[0]),
        .bus_write_data(b_wdata[0]), .bus_byte_enable(b_be[0]),
        .bus_read_enable(b_rd[0]), .bus_write_enable(b_wr[0]),
        .bus_read_data(b_rdata[0]), .bus_ready(b_ready[0]), .bus_error(b_error[0])
    );

    data_memory_bus_responder #(.WAIT_STATES(0)) u_dut_ws0 (
        .clock(clk), .reset(rst_n[1]), .bus_address(b_addr[1]),
        .bus_write_data(b_wdata[1]), .bus_byte_enable(b_be[1]),
        .bus_read_enable(b_rd[1]), .bus_write_enable(b_wr[1]),
        .bus_read_data(b_rdata[1]), .bus_ready(b_ready[1]), .bus_error(b_error[1])
    );

    data_memory_bus_responder #(.WAIT_STATES(3)) u_dut_ws3 (
        .clock(clk), .reset(rst_n[2]), .bus_address(b_addr[2]),
        .bus_write_data(b_wdata[2]), .bus_byte_enable(b_be[2]),
        .bus_read_enable(b_rd[2]), .bus_write_enable(b_wr[2]),
        .bus_read_data(b_rdata[2]), .bus_ready(b_ready[2]), .bus_error(b_error[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          inst;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    function automatic int ws_of(input int k);
        case (k)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    // Drive one request, wait (bounded) for ready, then drop the enables.
    task automatic run_txn(input int k, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                           output int lat, output logic timeout, output logic got_err,
                           output logic [31:0] got_rd, output logic ready_after);
        b_addr[k]  = a;
        b_wdata[k] = d;
        b_be[k]    = be;
        b_rd[k]    = rd;
        b_wr[k]    = wr;
        lat        = -1;
        timeout    = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (b_ready[k] === 1'b1) begin
                lat     = c;
                timeout = 1'b0;
                break;
            end
        end
        got_err = b_error[k];
        got_rd  = b_rdata[k];
        b_rd[k] = 1'b0;
        b_wr[k] = 1'b0;
        @(posedge clk);
        #1;
        ready_after = b_ready[k];
    endtask

    initial begin
        int          lat;
        logic        tmo;
        logic        gerr;
        logic [31:0] grd;
        logic        rdy_after;

        for (int k = 0; k < 3; k++) begin
            rst_n[k]   = 1'b0;
            b_addr[k]  = '0;
            b_wdata[k] = '0;
            b_be[k]    = '0;
            b_rd[k]    = 1'b0;
            b_wr[k]    = 1'b0;
        end

        //           inst rd    wr    addr          wdata         be     err   read_data
        vecs[0]  = '{0, 1'b0, 1'b1, 32'h8000_0010, 32'hCAFE_BABE, 4'hF, 1'b0, 32'h0000_0000};
        vecs[1]  = '{0, 1'b1, 1'b0, 32'h8000_0010, 32'h0000_0000, 4'h0, 1'b0, 32'hCAFE_BABE};
        vecs[2]  = '{0, 1'b0, 1'b1, 32'h8000_0010, 32'h1122_3344, 4'hF, 1'b0, 32'hCAFE_BABE};
        vecs[3]  = '{0, 1'b0, 1'b1, 32'h8000_0010, 32'hAABB_CCDD, 4'h5, 1'b0, 32'hCAFE_BABE};
        vecs[4]  = '{0, 1'b1, 1'b0, 32'h8000_0010, 32'h0000_0000, 4'h0, 1'b0, 32'h11BB_33DD};
        vecs[5]  = '{0, 1'b0, 1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 1'b0, 32'h11BB_33DD};
        vecs[6]  = '{0, 1'b1, 1'b0, 32'h8000_0013, 32'h0000_0000, 4'h0, 1'b0, 32'h11BB_33DD};
        vecs[7]  = '{0, 1'b1, 1'b0, 32'h7FFF_FFFC, 32'h0000_0000, 4'hF, 1'b1, 32'h0000_0000};
        vecs[8]  = '{0, 1'b0, 1'b1, 32'h8000_0000, 32'h0123_4567, 4'hF, 1'b0, 32'h0000_0000};
        vecs[9]  = '{0, 1'b0, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0000_0000};
        vecs[10] = '{0, 1'b1, 1'b0, 32'h8000_0000, 32'h0000_0000, 4'h0, 1'b0, 32'h0123_4567};
        vecs[11] = '{0, 1'b1, 1'b1, 32'h8000_0010, 32'h0000_0000, 4'hF, 1'b1, 32'h0000_0000};
        vecs[12] = '{0, 1'b1, 1'b0, 32'h8000_0010, 32'h0000_0000, 4'h0, 1'b0, 32'h11BB_33DD};
        vecs[13] = '{0, 1'b0, 1'b1, 32'h8000_0FFC, 32'h5A5A_0FFC, 4'hF, 1'b0, 32'h11BB_33DD};
        vecs[14] = '{0, 1'b1, 1'b0, 32'h8000_0FFF, 32'h0000_0000, 4'h0, 1'b0, 32'h5A5A_0FFC};
        vecs[15] = '{0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 4'h0, 1'b1, 32'h0000_0000};
        vecs[16] = '{1, 1'b0, 1'b1, 32'h8000_0020, 32'h0BAD_F00D, 4'hF, 1'b0, 32'h0000_0000};
        vecs[17] = '{1, 1'b1, 1'b0, 32'h8000_0020, 32'h0000_0000, 4'h0, 1'b0, 32'h0BAD_F00D};
        vecs[18] = '{1, 1'b1, 1'b0, 32'h8000_1000, 32'h0000_0000, 4'h0, 1'b1, 32'h0000_0000};
        vecs[19] = '{2, 1'b0, 1'b1, 32'h8000_0040, 32'h4444_4444, 4'hF, 1'b0, 32'h0000_0000};
        vecs[20] = '{2, 1'b1, 1'b0, 32'h8000_0040, 32'h0000_0000, 4'h0, 1'b0, 32'h4444_4444};

        // Reset low for three cycles, then ten idle cycles with quiet outputs.
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                check($sformatf("idle c%0d i%0d", c, k),
                      {b_rdata[k], 1'b0, 1'b0}[31:0] | 32'(b_ready[k]) | 32'(b_error[k]),
                      32'h0);
            end
        end

        for (int v = 0; v < NV; v++) begin
            run_txn(vecs[v].inst, vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wdata,
                    vecs[v].be, lat, tmo, gerr, grd, rdy_after);
            check($sformatf("v%0d timeout", v), 32'(tmo), 32'h0);
            check($sformatf("v%0d latency", v), 32'(lat), 32'(ws_of(vecs[v].inst)));
            check($sformatf("v%0d error", v), 32'(gerr), 32'(vecs[v].exp_err));
            check($sformatf("v%0d read_data", v), grd, vecs[v].exp_rd);
            check($sformatf("v%0d ready pulse width", v), 32'(rdy_after), 32'h0);
        end

        // Reset during the wait states of a write on the 3-wait-state instance.
        b_addr[2]  = 32'h8000_0040;
        b_wdata[2] = 32'h9999_9999;
        b_be[2]    = 4'hF;
        b_wr[2]    = 1'b1;
        @(posedge clk);
        #1;
        check("midrst accept ready", 32'(b_ready[2]), 32'h0);
        @(posedge clk);
        #1;
        rst_n[2] = 1'b0;
        b_wr[2]  = 1'b0;
        #1;
        check("midrst in-reset ready", 32'(b_ready[2]), 32'h0);
        check("midrst in-reset read_data", b_rdata[2], 32'h0);
        @(posedge clk);
        #1;
        rst_n[2] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("midrst post c%0d ready", c), 32'(b_ready[2]), 32'h0);
        end
        run_txn(2, 1'b1, 1'b0, 32'h8000_0040, 32'h0, 4'h0, lat, tmo, gerr, grd, rdy_after);
        check("midrst readback timeout", 32'(tmo), 32'h0);
        check("midrst readback latency", 32'(lat), 32'd3);
        check("midrst readback error", 32'(gerr), 32'h0);
        check("midrst readback data", grd, 32'h4444_4444);

        // Enables left high in IDLE after a response start a fresh request.
        b_addr[0] = 32'h8000_0000;
        b_rd[0]   = 1'b1;
        lat = -1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (b_ready[0] === 1'b1) begin
                lat = c;
                break;
            end
        end
        check("b2b first latency", 32'(lat), 32'd1);
        lat = -1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (b_ready[0] === 1'b1) begin
                lat = c;
                break;
            end
        end
        b_rd[0] = 1'b0;
        // RESP returns to IDLE (1 edge), then accept + 1 wait state.
        check("b2b second latency", 32'(lat), 32'd2);
        check("b2b second data", b_rdata[0], 32'h0123_4567);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

endmodule
